// File: rtl/lcd_pixel_reader.sv
// lcd_pixel_reader: oversampling receiver for the parallel RGB LCD bus.
// Recovers x/y-tagged pixels and checks line/frame geometry.
module lcd_pixel_reader #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int X_W             = 10,
  parameter int Y_W             = 10
) (
  input  logic           clk_50mhz,
  input  logic           rst,
  input  logic [23:0]    lcd_rgb,
  input  logic           lcd_dclk,
  input  logic           lcd_disp_en,
  input  logic           lcd_hsync,
  input  logic           lcd_vsync,
  input  logic           lcd_den,
  output logic [23:0]    pix_rgb,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_valid,
  output logic           line_start,
  output logic           frame_start,
  output logic           frame_done,
  output logic [X_W-1:0] line_len,
  output logic [Y_W-1:0] line_cnt,
  output logic           line_err,
  output logic           frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic [28:0] bus_in, s1, s2;
  logic        dclk_q;

  logic [23:0] rgb_s;
  logic        dclk_s, disp_s, vs_s, den_s;
  logic        sync_unused;

  logic        sample, vs_act, vs_edge, vs_prev, vsp_n;
  logic        close, go_blank, go_act;

  logic [X_W-1:0] x, x_n, x_inc, x_p1;
  logic [Y_W-1:0] y, y_n, y_inc, y_cl;

  logic [23:0]    rgb_n;
  logic [X_W-1:0] px_n, len_n;
  logic [Y_W-1:0] py_n, cnt_n;
  logic           pv_n, ls_n, fs_n, fd_n, le_n, fe_n;

  assign bus_in = {lcd_rgb, lcd_dclk, lcd_disp_en,
                   lcd_hsync, lcd_vsync, lcd_den};

  assign rgb_s       = s2[28:5];
  assign dclk_s      = s2[4];
  assign disp_s      = s2[3];
  assign sync_unused = s2[2];
  assign vs_s        = s2[1];
  assign den_s       = s2[0];

  assign sample  = dclk_s & ~dclk_q;
  assign vs_act  = SYNC_ACTIVE_LOW ? ~vs_s : vs_s;
  assign vs_edge = vs_act & ~vs_prev;

  assign close    = (state != IDLE) & (~disp_s | vs_edge);
  assign go_blank = (state == VBLANK) & ~close;
  assign go_act   = (state == ACTIVE) & ~close;

  assign x_p1  = x + X_W'(1);
  assign x_inc = (x == '1) ? x : x_p1;
  assign y_inc = (y == '1) ? y : y + Y_W'(1);

  // Two-stage synchroniser on the whole bus plus dclk edge history
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      s1     <= '0;
      s2     <= '0;
      dclk_q <= 1'b0;
    end else begin
      s1     <= bus_in;
      s2     <= s1;
      dclk_q <= dclk_s;
    end
  end

  // State register
  always_ff @(posedge clk_50mhz) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state, counters and registered outputs at each sample
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    vsp_n   = vs_prev;
    y_cl    = y;
    rgb_n   = pix_rgb;
    px_n    = pix_x;
    py_n    = pix_y;
    len_n   = line_len;
    cnt_n   = line_cnt;
    pv_n    = 1'b0;
    ls_n    = 1'b0;
    fs_n    = 1'b0;
    fd_n    = 1'b0;
    le_n    = 1'b0;
    fe_n    = 1'b0;
    if (sample) begin
      vsp_n = vs_act;
      if (state == ACTIVE) y_cl = y_inc;
      unique case (1'b1)
        (state == IDLE): begin
          if (disp_s && vs_edge) begin
            state_n = VBLANK;
            fs_n    = 1'b1;
            y_n     = '0;
          end
        end
        close: begin
          if (state == ACTIVE) begin
            len_n = x_p1;
            le_n  = (x_p1 != X_W'(H_ACTIVE));
          end
          cnt_n = y_cl;
          fd_n  = 1'b1;
          fe_n  = (y_cl != Y_W'(V_ACTIVE));
          if (disp_s) begin
            fs_n    = 1'b1;
            y_n     = '0;
            state_n = VBLANK;
          end else begin
            y_n     = y_cl;
            state_n = IDLE;
          end
        end
        go_blank: begin
          if (den_s) begin
            state_n = ACTIVE;
            x_n     = '0;
            pv_n    = 1'b1;
            ls_n    = 1'b1;
            rgb_n   = rgb_s;
            px_n    = '0;
            py_n    = y;
          end
        end
        go_act: begin
          if (den_s) begin
            x_n   = x_inc;
            pv_n  = 1'b1;
            rgb_n = rgb_s;
            px_n  = x_inc;
            py_n  = y;
          end else begin
            len_n   = x_p1;
            le_n    = (x_p1 != X_W'(H_ACTIVE));
            y_n     = y_inc;
            state_n = VBLANK;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Counters and output registers
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      vs_prev     <= 1'b0;
      pix_rgb     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_len    <= '0;
      line_cnt    <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      x           <= x_n;
      y           <= y_n;
      vs_prev     <= vsp_n;
      pix_rgb     <= rgb_n;
      pix_x       <= px_n;
      pix_y       <= py_n;
      pix_valid   <= pv_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
      frame_done  <= fd_n;
      line_len    <= len_n;
      line_cnt    <= cnt_n;
      line_err    <= le_n;
      frame_err   <= fe_n;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_reader.sv
// tb_lcd_pixel_reader: drives LCD frames on a scaled geometry and
// compares every strobe cycle with events predicted from the frame plan.
module tb_lcd_pixel_reader;

  localparam int H = 24;
  localparam int V = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] lcd_rgb = '0;
  logic        lcd_dclk = 1'b0;
  logic        lcd_disp_en = 1'b1;
  logic        lcd_hsync = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_den = 1'b0;

  logic [23:0] pix_rgb;
  logic [9:0]  pix_x, pix_y, line_len, line_cnt;
  logic        pix_valid, line_start, frame_start, frame_done;
  logic        line_err, frame_err;

  lcd_pixel_reader #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk_50mhz   (clk),
    .rst         (rst),
    .lcd_rgb     (lcd_rgb),
    .lcd_dclk    (lcd_dclk),
    .lcd_disp_en (lcd_disp_en),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_den     (lcd_den),
    .pix_rgb     (pix_rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_len    (line_len),
    .line_cnt    (line_cnt),
    .line_err    (line_err),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        pv, ls, fs, fd, le, fe;
    logic [23:0] rgb;
    logic [9:0]  x, y, len, cnt;
  } ev_t;

  ev_t expq[$];
  int  total = 0;
  int  bad = 0;
  int  npix_exp = 0;
  int  npix_got = 0;

  bit  cap = 0;
  int  row = 0;
  int  last_len = 0;
  int  last_cnt = 0;

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic ev_t mk(bit pv, bit ls, bit fs, bit fd,
                             bit le, bit fe, logic [23:0] c,
                             int x, int y, int len, int cnt);
    ev_t e;
    e.pv  = pv;
    e.ls  = ls;
    e.fs  = fs;
    e.fd  = fd;
    e.le  = le;
    e.fe  = fe;
    e.rgb = pv ? c : 24'h0;
    e.x   = pv ? 10'(x) : 10'h0;
    e.y   = pv ? 10'(y) : 10'h0;
    e.len = 10'(len);
    e.cnt = 10'(cnt);
    return e;
  endfunction

  ev_t mo, me;

  always @(negedge clk) begin
    if (pix_valid | line_start | frame_start |
        frame_done | line_err | frame_err) begin
      mo = mk(pix_valid, line_start, frame_start, frame_done,
              line_err, frame_err, pix_rgb, int'(pix_x),
              int'(pix_y), int'(line_len), int'(line_cnt));
      if (pix_valid) npix_got++;
      chk("strobe_expected", 128'(expq.size() != 0), 128'(1));
      if (expq.size() != 0) begin
        me = expq.pop_front();
        chk(me.pv ? "pixel" : me.fd ? "frame_close" :
            me.fs ? "frame_start" : "line_err",
            128'(mo), 128'(me));
      end
    end
  end

  // one lcd_dclk period: data changes while dclk low, rise after 2 clks
  task automatic tick(input bit d, input logic [23:0] c,
                      input bit vs, input bit de);
    @(posedge clk);
    #3;
    lcd_dclk    = 1'b0;
    lcd_den     = d;
    lcd_rgb     = c;
    lcd_vsync   = ~vs;
    lcd_disp_en = de;
    lcd_hsync   = 1'($urandom);
    @(posedge clk);
    @(posedge clk);
    #3;
    lcd_dclk = 1'b1;
    @(posedge clk);
  endtask

  // same as tick but checks the strobe timing edge by edge
  task automatic tick_lat(input logic [23:0] c);
    @(posedge clk);
    #3;
    lcd_dclk = 1'b0;
    lcd_den  = 1'b1;
    lcd_rgb  = c;
    lcd_vsync = 1'b1;
    lcd_disp_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    lcd_dclk = 1'b1;
    @(posedge clk);
    #1 chk("lat_edge1", 128'(pix_valid), 128'(0));
    @(posedge clk);
    #1 chk("lat_edge2", 128'(pix_valid), 128'(0));
    @(posedge clk);
    #1 chk("lat_edge3", {pix_valid, line_start, pix_x, pix_y},
           {1'b1, 1'b1, 10'd0, 10'd0});
    @(posedge clk);
    #1 chk("lat_edge4", 128'(pix_valid), 128'(0));
  endtask

  task automatic pixels(input int n, input bit solid,
                        input bit de, input bit lat);
    logic [23:0] c;
    for (int i = 0; i < n; i++) begin
      c = solid ? 24'h0000ff : 24'($urandom);
      if (cap && de) begin
        expq.push_back(mk(1, i == 0, 0, 0, 0, 0, c, i, row,
                          last_len, last_cnt));
        npix_exp++;
      end
      if (lat && i == 0) tick_lat(c);
      else tick(1, c, 0, de);
    end
  endtask

  task automatic line(input int n, input int gap, input bit solid,
                      input bit de, input bit lat);
    pixels(n, solid, de, lat);
    if (cap) begin
      if (n != H)
        expq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, n, last_cnt));
      last_len = n;
      row++;
    end
    repeat (gap) tick(0, 24'($urandom), 0, de);
  endtask

  task automatic vsync(input int w, input bit de);
    if (de) begin
      if (cap) begin
        expq.push_back(mk(0, 0, 1, 1, 0, row != V, 0, 0, 0,
                          last_len, row));
        last_cnt = row;
      end else begin
        expq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,
                          last_len, last_cnt));
      end
      cap = 1;
      row = 0;
    end
    repeat (w) tick(0, 24'($urandom), 1, de);
    tick(0, 24'($urandom), 0, de);
  endtask

  task automatic line_vs(input int n);
    pixels(n, 0, 1, 0);
    expq.push_back(mk(0, 0, 1, 1, n != H, (row + 1) != V, 0, 0, 0,
                      n, row + 1));
    last_len = n;
    last_cnt = row + 1;
    row = 0;
    tick(1, 24'($urandom), 1, 1);
    tick(0, 24'($urandom), 1, 1);
    tick(0, 24'($urandom), 0, 1);
  endtask

  task automatic drop();
    if (cap) begin
      expq.push_back(mk(0, 0, 0, 1, 0, row != V, 0, 0, 0,
                        last_len, row));
      last_cnt = row;
    end
    cap = 0;
    tick(0, 24'($urandom), 0, 0);
  endtask

  task automatic frame(input bit solid);
    for (int r = 0; r < V; r++)
      line(H, $urandom_range(2, 4), solid, 1, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 chk("reset_outputs",
           {pix_rgb, pix_x, pix_y, pix_valid, line_start,
            frame_start, frame_done, line_len, line_cnt,
            line_err, frame_err}, '0);
    #2 rst = 1'b1;

    // pixels before any vsync edge are ignored
    repeat (3) tick(0, 24'h0, 0, 1);
    line(H, 3, 0, 1, 0);

    // two clean solid-blue frames
    vsync(2, 1);
    frame(1);
    vsync(2, 1);
    frame(1);
    vsync(2, 1);
    chk("line_cnt_clean", 128'(line_cnt), 128'(V));

    // latency on the first pixel of a frame, then a short row 5
    line(1, 3, 0, 1, 1);
    for (int r = 1; r < 5; r++) line(H, 3, 0, 1, 0);
    line(H - 1, 3, 0, 1, 0);
    chk("line_len_short", 128'(line_len), 128'(H - 1));
    line(H, 3, 0, 1, 0);
    chk("line_len_next", 128'(line_len), 128'(H));
    for (int r = 7; r < V; r++) line(H, 3, 0, 1, 0);
    vsync(2, 1);

    // vsync mid-line at x=10 of row 10
    for (int r = 0; r < 10; r++) line(H, 2, 0, 1, 0);
    line_vs(10);
    chk("line_cnt_trunc", 128'(line_cnt), 128'(11));

    // disp_en dropped at row 5 while d_en keeps pulsing
    for (int r = 0; r < 5; r++)
      line($urandom_range(H - 4, H + 2), 3, 0, 1, 0);
    drop();
    line(H, 3, 0, 0, 0);
    line(H, 3, 0, 0, 0);
    vsync(2, 0);
    line(H, 3, 0, 1, 0);
    vsync(2, 1);

    // reset mid-line at x=10 of row 3
    for (int r = 0; r < 3; r++) line(H, 3, 0, 1, 0);
    pixels(11, 0, 1, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    cap = 0;
    row = 0;
    last_len = 0;
    last_cnt = 0;
    @(posedge clk);
    #1 chk("midline_reset",
           {pix_rgb, pix_x, pix_y, pix_valid, line_start,
            frame_start, frame_done, line_len, line_cnt,
            line_err, frame_err}, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    line(H, 3, 0, 1, 0);
    vsync(2, 1);
    frame(0);
    vsync(2, 1);
    chk("line_cnt_after_reset", 128'(line_cnt), 128'(V));

    repeat (20) @(posedge clk);
    chk("queue_drained", 128'(expq.size()), 128'(0));
    chk("pix_count", 128'(npix_got), 128'(npix_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
